// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Answers the fetch PC query combinationally and absorbs resolved-branch updates on the clock edge.
module branch_predictor #(
    parameter int IDX_W = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] query_pc_in,
    output logic        predict_taken_out,
    output logic [31:0] predict_pc_out,
    input  logic        update_valid_in,
    input  logic [31:0] update_pc_in,
    input  logic        update_taken_in,
    input  logic [31:0] update_target_in,
    input  logic        mispredict_in,
    output logic [31:0] branch_cnt_out,
    output logic [31:0] miss_cnt_out
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    logic             r_valid  [DEPTH];
    logic [TAG_W-1:0] r_tag    [DEPTH];
    logic [31:0]      r_target [DEPTH];
    logic [1:0]       r_cnt    [DEPTH];
    logic [31:0]      r_branchCnt;
    logic [31:0]      r_missCnt;

    logic [IDX_W-1:0] w_qIdx;
    logic [TAG_W-1:0] w_qTag;
    logic             w_qHit;
    logic [31:0]      w_pcPlus4;
    logic [IDX_W-1:0] w_uIdx;
    logic [TAG_W-1:0] w_uTag;
    logic             w_uHit;
    logic [1:0]       w_cntInc;
    logic [1:0]       w_cntDec;
    logic             w_unused;

    assign w_qIdx    = query_pc_in[IDX_W+1:2];
    assign w_qTag    = query_pc_in[31:IDX_W+2];
    assign w_qHit    = r_valid[w_qIdx] && (r_tag[w_qIdx] == w_qTag);
    assign w_pcPlus4 = query_pc_in + 32'd4;

    assign w_uIdx   = update_pc_in[IDX_W+1:2];
    assign w_uTag   = update_pc_in[31:IDX_W+2];
    assign w_uHit   = r_valid[w_uIdx] && (r_tag[w_uIdx] == w_uTag);
    assign w_cntInc = (r_cnt[w_uIdx] == 2'b11) ? 2'b11 : r_cnt[w_uIdx] + 2'b01;
    assign w_cntDec = (r_cnt[w_uIdx] == 2'b00) ? 2'b00 : r_cnt[w_uIdx] - 2'b01;

    // Byte offset bits never select an entry; keep them visibly consumed.
    assign w_unused = ^{query_pc_in[1:0], update_pc_in[1:0]};

    always_comb begin
        predict_taken_out = 1'b0;
        predict_pc_out    = w_pcPlus4;
        if (rst_in && w_qHit && r_cnt[w_qIdx][1]) begin
            predict_taken_out = 1'b1;
            predict_pc_out    = r_target[w_qIdx];
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= 2'b01;
            end
            r_branchCnt <= '0;
            r_missCnt   <= '0;
        end else if (rdy_in && update_valid_in) begin
            if (update_taken_in) begin
                r_target[w_uIdx] <= update_target_in;
                if (w_uHit) begin
                    r_cnt[w_uIdx] <= w_cntInc;
                end else begin
                    // Reallocation never inherits the evicted entry's history.
                    r_valid[w_uIdx] <= 1'b1;
                    r_tag[w_uIdx]   <= w_uTag;
                    r_cnt[w_uIdx]   <= 2'b10;
                end
            end else if (w_uHit) begin
                r_cnt[w_uIdx] <= w_cntDec;
            end
            r_branchCnt <= r_branchCnt + 32'd1;
            if (mispredict_in) begin
                r_missCnt <= r_missCnt + 32'd1;
            end
        end
    end

    assign branch_cnt_out = r_branchCnt;
    assign miss_cnt_out   = r_missCnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by random traffic,
// both checked against a behavioural table model held in the bench.
module tb_branch_predictor;

    localparam int IDX_W = 6;
    localparam int DEPTH = 1 << IDX_W;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [31:0] queryPc;
    logic        predTaken;
    logic [31:0] predPc;
    logic        updValid;
    logic [31:0] updPc;
    logic        updTaken;
    logic [31:0] updTarget;
    logic        mispredict;
    logic [31:0] branchCnt;
    logic [31:0] missCnt;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model: plain arrays indexed by table slot.
    bit          mValid  [DEPTH];
    logic [31:0] mTag    [DEPTH];
    logic [31:0] mTarget [DEPTH];
    int          mCnt    [DEPTH];
    logic [31:0] mBranch;
    logic [31:0] mMiss;

    branch_predictor #(.IDX_W(IDX_W)) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .rdy_in           (rdy),
        .query_pc_in      (queryPc),
        .predict_taken_out(predTaken),
        .predict_pc_out   (predPc),
        .update_valid_in  (updValid),
        .update_pc_in     (updPc),
        .update_taken_in  (updTaken),
        .update_target_in (updTarget),
        .mispredict_in    (mispredict),
        .branch_cnt_out   (branchCnt),
        .miss_cnt_out     (missCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int slotOf(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic logic [31:0] tagOf(input logic [31:0] pc);
        return pc >> (IDX_W + 2);
    endfunction

    function automatic bit modelTaken(input logic [31:0] pc);
        int s;
        s = slotOf(pc);
        return rst && mValid[s] && (mTag[s] == tagOf(pc)) && (mCnt[s] >= 2);
    endfunction

    function automatic logic [31:0] modelPc(input logic [31:0] pc);
        return modelTaken(pc) ? mTarget[slotOf(pc)] : pc + 32'd4;
    endfunction

    // Applies the edge behaviour to the model using the inputs held across that edge.
    task automatic modelEdge();
        int  s;
        bit  hit;
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mValid[i]  = 1'b0;
                mTag[i]    = '0;
                mTarget[i] = '0;
                mCnt[i]    = 1;
            end
            mBranch = '0;
            mMiss   = '0;
        end else if (rdy && updValid) begin
            s   = slotOf(updPc);
            hit = mValid[s] && (mTag[s] == tagOf(updPc));
            if (updTaken && hit) begin
                mTarget[s] = updTarget;
                mCnt[s]    = (mCnt[s] + 1 > 3) ? 3 : mCnt[s] + 1;
            end else if (updTaken) begin
                mValid[s]  = 1'b1;
                mTag[s]    = tagOf(updPc);
                mTarget[s] = updTarget;
                mCnt[s]    = 2;
            end else if (hit) begin
                mCnt[s] = (mCnt[s] - 1 < 0) ? 0 : mCnt[s] - 1;
            end
            mBranch = mBranch + 32'd1;
            if (mispredict) mMiss = mMiss + 32'd1;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rd, input logic uv,
                                 input logic [31:0] upc, input logic ut,
                                 input logic [31:0] utgt, input logic mis,
                                 input logic [31:0] qpc);
        rst        = r;
        rdy        = rd;
        updValid   = uv;
        updPc      = upc;
        updTaken   = ut;
        updTarget  = utgt;
        mispredict = mis;
        queryPc    = qpc;
        #1;
    endtask

    task automatic clockEdge();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic checkValue(input string name, input logic [31:0] observed,
                              input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", name, observed, expected);
        end
    endtask

    task automatic checkOutput(input string name);
        checkValue({name, ".taken"}, {31'd0, predTaken}, {31'd0, modelTaken(queryPc)});
        checkValue({name, ".pc"}, predPc, modelPc(queryPc));
        checkValue({name, ".branchCnt"}, branchCnt, mBranch);
        checkValue({name, ".missCnt"}, missCnt, mMiss);
    endtask

    initial begin
        logic [31:0] savedBranch;
        logic [31:0] rpc;

        mBranch = '0;
        mMiss   = '0;

        applyStimulus(0, 1, 1, 32'h1000, 1, 32'h1200, 1, 32'h1000);
        clockEdge();
        clockEdge();
        checkOutput("inReset");

        applyStimulus(1, 1, 0, 0, 0, 0, 0, 32'h1000);
        checkOutput("resetQuery");
        checkValue("resetQuery.constPc", predPc, 32'h1004);
        checkValue("resetQuery.constBranch", branchCnt, 32'd0);

        applyStimulus(1, 1, 1, 32'h1000, 1, 32'h1200, 0, 32'h1000);
        clockEdge();
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 32'h1000);
        checkOutput("allocate");
        checkValue("allocate.constPc", predPc, 32'h1200);
        checkValue("allocate.constBranch", branchCnt, 32'd1);

        applyStimulus(1, 1, 1, 32'h1000, 0, 0, 1, 32'h1000);
        clockEdge();
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 32'h1000);
        checkOutput("hystNt1");
        checkValue("hystNt1.constPc", predPc, 32'h1004);

        applyStimulus(1, 1, 1, 32'h1000, 0, 0, 0, 32'h1000);
        clockEdge();
        applyStimulus(1, 1, 1, 32'h1000, 1, 32'h1200, 1, 32'h1000);
        clockEdge();
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 32'h1000);
        checkOutput("hystFloor");
        checkValue("hystFloor.constPc", predPc, 32'h1004);

        applyStimulus(1, 1, 1, 32'h1000, 1, 32'h1200, 0, 32'h1000);
        clockEdge();
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 32'h1000);
        checkOutput("hystRecover");
        checkValue("hystRecover.constPc", predPc, 32'h1200);

        applyStimulus(1, 1, 1, 32'h1100, 1, 32'h1300, 1, 32'h1100);
        clockEdge();
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 32'h1000);
        checkValue("aliasOld.constPc", predPc, 32'h1004);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 32'h1100);
        checkOutput("aliasNew");
        checkValue("aliasNew.constPc", predPc, 32'h1300);

        applyStimulus(1, 1, 1, 32'h2000, 1, 32'h2400, 0, 32'h2000);
        checkValue("bypassSame.constPc", predPc, 32'h2004);
        clockEdge();
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 32'h2000);
        checkValue("bypassNext.constPc", predPc, 32'h2400);

        savedBranch = branchCnt;
        applyStimulus(1, 0, 1, 32'h3000, 1, 32'h3400, 1, 32'h3000);
        checkValue("rdyLowSame.constPc", predPc, 32'h3004);
        clockEdge();
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 32'h3000);
        checkOutput("rdyLow");
        checkValue("rdyLow.constPc", predPc, 32'h3004);
        checkValue("rdyLow.branchHeld", branchCnt, savedBranch);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 32'h2000);
        checkValue("rdyLow.keepOld", predPc, 32'h2400);

        force dut.r_missCnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_missCnt;
        mMiss = 32'hFFFF_FFFF;
        savedBranch = branchCnt;
        applyStimulus(1, 1, 1, 32'h2000, 0, 0, 1, 32'h2000);
        clockEdge();
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 32'h2000);
        checkOutput("statWrap");
        checkValue("statWrap.constMiss", missCnt, 32'd0);
        checkValue("statWrap.branchInc", branchCnt, savedBranch + 32'd1);

        applyStimulus(0, 1, 1, 32'h4000, 1, 32'h4400, 1, 32'h4000);
        clockEdge();
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 32'h1100);
        checkOutput("midReset");
        checkValue("midReset.constPc", predPc, 32'h1104);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 32'h4000);
        checkValue("midReset.dropUpd", predPc, 32'h4004);

        // Small PC pool: 4 tags x 8 slots forces frequent aliasing and repeat hits.
        for (int n = 0; n < 400; n++) begin
            rpc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
                  | 32'($urandom_range(0, 3));
            applyStimulus(($urandom_range(0, 39) != 0), ($urandom_range(0, 7) != 0),
                          1'($urandom_range(0, 1)), rpc, 1'($urandom_range(0, 1)),
                          $urandom, 1'($urandom_range(0, 1)),
                          (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2));
            checkOutput("random");
            clockEdge();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
